// File: rtl/fd_corner_collector.sv
// Corner collector behind the FAST-9 detector: drops border pixels, buffers corner addresses
// in a FIFO with a registered head, and tracks per-frame count, overflow and frame completion.
module fd_corner_collector #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned LOG2_W = 7,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned BORDER = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       frameStart,
  input  logic                       frameEnd,
  input  logic                       resValid,
  input  logic                       isCorner,
  input  logic [ADDR_W-1:0]          refAddr,
  output logic                       cornerValid,
  input  logic                       cornerReady,
  output logic [ADDR_W-1:0]          cornerAddr,
  output logic [$clog2(DEPTH):0]     fifoLevel,
  output logic [ADDR_W-1:0]          cornerCount,
  output logic                       overflow,
  output logic                       frameDone
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam int unsigned YW   = ADDR_W - LOG2_W;

  localparam logic [LOG2_W-1:0] XMin = LOG2_W'(BORDER);
  localparam logic [LOG2_W-1:0] XMax = LOG2_W'((2 ** LOG2_W) - 1 - BORDER);
  localparam logic [YW-1:0]     YMin = YW'(BORDER);
  localparam logic [YW-1:0]     YMax = YW'((2 ** YW) - 1 - BORDER);

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StDrain,
    StDone
  } stateE;

  stateE state;

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PtrW-1:0]   wrPtr;
  logic [PtrW-1:0]   rdPtr;
  logic [PtrW-1:0]   rdNext;
  logic [LvlW-1:0]   levelNext;
  logic [LvlW-1:0]   remain;
  logic [ADDR_W-1:0] headNext;

  logic [LOG2_W-1:0] pixX;
  logic [YW-1:0]     pixY;
  logic              inBorder;
  logic              accept;
  logic              full;
  logic              push;
  logic              pop;
  logic              drop;

  assign pixX = refAddr[LOG2_W-1:0];
  assign pixY = refAddr[ADDR_W-1:LOG2_W];

  assign inBorder = (pixX >= XMin) && (pixX <= XMax) && (pixY >= YMin) && (pixY <= YMax);
  assign accept   = (state == StCollect) && resValid && isCorner && inBorder;
  assign full     = (fifoLevel == LvlW'(DEPTH));
  assign pop      = cornerValid && cornerReady;
  assign push     = accept && (!full || pop);
  assign drop     = accept && full && !pop;

  assign rdNext = rdPtr + PtrW'(pop);
  assign remain = fifoLevel - LvlW'(pop);

  always_comb begin
    levelNext = fifoLevel;
    if (push && !pop) begin
      levelNext = fifoLevel + LvlW'(1);
    end else if (!push && pop) begin
      levelNext = fifoLevel - LvlW'(1);
    end
  end

  // Head register: a push into a FIFO that is empty after this cycle's pop becomes the head
  // directly; otherwise the head is the next stored entry (never the slot being written).
  always_comb begin
    headNext = cornerAddr;
    if (remain == '0) begin
      if (push) begin
        headNext = refAddr;
      end
    end else begin
      headNext = mem[rdNext];
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wrPtr] <= refAddr;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= StIdle;
      wrPtr       <= '0;
      rdPtr       <= '0;
      fifoLevel   <= '0;
      cornerValid <= 1'b0;
      cornerAddr  <= '0;
      cornerCount <= '0;
      overflow    <= 1'b0;
      frameDone   <= 1'b0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + PtrW'(1);
      end
      rdPtr       <= rdNext;
      fifoLevel   <= levelNext;
      cornerValid <= (levelNext != '0);
      cornerAddr  <= headNext;

      if (push && (cornerCount != '1)) begin
        cornerCount <= cornerCount + ADDR_W'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
      end

      frameDone <= 1'b0;
      unique case (state)
        StIdle: begin
          if (frameStart) begin
            state       <= StCollect;
            cornerCount <= '0;
            overflow    <= 1'b0;
          end
        end
        StCollect: begin
          if (frameEnd) begin
            state <= StDrain;
          end
        end
        StDrain: begin
          if ((fifoLevel == '0) && !pop) begin
            state     <= StDone;
            frameDone <= 1'b1;
          end
        end
        StDone: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule
